// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage control, memory and decode-side signal bundle
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [7:0]        instruction;
  logic [ADDR_W-1:0] read_address;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              halted;

  // driving side: control, memory data in; observes fetch outputs
  modport master (
    output start, stall, redirect, redirect_target, instruction,
    input  read_address, ir, ir_pc, ir_valid, halted
  );

  // fetch unit side
  modport slave (
    input  start, stall, redirect, redirect_target, instruction,
    output read_address, ir, ir_pc, ir_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and IF/ID latch with stall, redirect and halt
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter int         ADDR_W      = 8
) (
  input logic        clk,
  input logic        reset_n,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              halted;

  // memory is addressed straight from the pc; outputs come from registers
  assign bus.read_address = pc;
  assign bus.ir           = ir;
  assign bus.ir_pc        = ir_pc;
  assign bus.ir_valid     = ir_valid;
  assign bus.halted       = halted;

  // fetch state machine: redirect beats stall beats fetch while running
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= ADDR_W'(RESET_PC);
      ir       <= 8'h00;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          // redirect while idle presets the boot address
          if (bus.redirect) pc <= bus.redirect_target;
          if (bus.start) state <= RUN;
        end
        RUN: begin
          if (bus.redirect) begin
            // drop the wrong-path instruction; ir/ir_pc keep their old values
            pc       <= bus.redirect_target;
            ir_valid <= 1'b0;
          end else if (!bus.stall) begin
            ir       <= bus.instruction;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (bus.instruction == HALT_OPCODE) begin
              // pc stays parked on the halt address
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        HALT: begin
          // only reset leaves here; every other input is ignored
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ir_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic reset_n;
  logic halt_en;

  fetch_unit_if #(.ADDR_W(8)) bus ();

  fetch_unit #(
    .RESET_PC   (8'h00),
    .HALT_OPCODE(8'hFF),
    .ADDR_W     (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: word at address a is a+0x10, or the halt opcode when armed at 0x03
  always_comb begin
    bus.instruction = bus.read_address + 8'h10;
    if (halt_en && bus.read_address == 8'h03) bus.instruction = 8'hFF;
  end

  typedef struct {
    logic       rn;
    logic       st;
    logic       sl;
    logic       rd;
    logic [7:0] tgt;
    logic       he;
    logic [7:0] ra;
    logic [7:0] ir;
    logic [7:0] irpc;
    logic       v;
    logic       h;
    logic       hc;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] ra;
    logic [7:0] ir;
    logic [7:0] irpc;
    logic       v;
    logic       h;
    logic       hc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks;
  int   failures;

  function automatic void add(input logic rn, input logic st, input logic sl, input logic rd,
                              input logic [7:0] tgt, input logic he, input logic [7:0] ra,
                              input logic [7:0] ir, input logic [7:0] irpc, input logic v,
                              input logic h, input logic hc);
    vec_t t;
    t.rn = rn; t.st = st; t.sl = sl; t.rd = rd; t.tgt = tgt; t.he = he;
    t.ra = ra; t.ir = ir; t.irpc = irpc; t.v = v; t.h = h; t.hc = hc;
    tbl.push_back(t);
  endfunction

  task automatic check8(input int idx, input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL v%0d %s got=%h exp=%h", idx, name, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    halt_en  = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 8'h00;

    //   rn st sl rd tgt    he  ra     ir     irpc   v  h  hc
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 0 reset
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 1 idle, no fetch
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 2 start
    add(1, 0, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h00, 1, 0, 1); // 3
    add(1, 0, 0, 0, 8'h00, 0, 8'h02, 8'h11, 8'h01, 1, 0, 1); // 4
    add(1, 0, 0, 0, 8'h00, 0, 8'h03, 8'h12, 8'h02, 1, 0, 1); // 5
    add(1, 0, 0, 0, 8'h00, 0, 8'h04, 8'h13, 8'h03, 1, 0, 1); // 6
    add(1, 0, 0, 0, 8'h00, 0, 8'h05, 8'h14, 8'h04, 1, 0, 1); // 7 pc=05
    add(1, 0, 1, 0, 8'h00, 0, 8'h05, 8'h14, 8'h04, 1, 0, 1); // 8 stall x3
    add(1, 0, 1, 0, 8'h00, 0, 8'h05, 8'h14, 8'h04, 1, 0, 1); // 9
    add(1, 0, 1, 0, 8'h00, 0, 8'h05, 8'h14, 8'h04, 1, 0, 1); // 10
    add(1, 0, 0, 0, 8'h00, 0, 8'h06, 8'h15, 8'h05, 1, 0, 1); // 11 resume at 05
    add(1, 0, 0, 0, 8'h00, 0, 8'h07, 8'h16, 8'h06, 1, 0, 1); // 12 pc=07
    add(1, 0, 1, 1, 8'h40, 0, 8'h40, 8'h16, 8'h06, 0, 0, 1); // 13 redirect under stall
    add(1, 0, 0, 0, 8'h00, 0, 8'h41, 8'h50, 8'h40, 1, 0, 1); // 14 target valid
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 15 reset
    add(1, 0, 0, 1, 8'hFE, 0, 8'hFE, 8'h00, 8'h00, 0, 0, 1); // 16 preset in idle
    add(1, 1, 0, 0, 8'h00, 0, 8'hFE, 8'h00, 8'h00, 0, 0, 1); // 17 start
    add(1, 0, 0, 0, 8'h00, 0, 8'hFF, 8'h0E, 8'hFE, 1, 0, 1); // 18
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h0F, 8'hFF, 1, 0, 1); // 19 wrap
    add(1, 0, 0, 0, 8'h00, 0, 8'h01, 8'h10, 8'h00, 1, 0, 1); // 20
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 21 reset
    add(1, 1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 22 start, halt armed
    add(1, 0, 0, 0, 8'h00, 1, 8'h01, 8'h10, 8'h00, 1, 0, 1); // 23
    add(1, 0, 0, 0, 8'h00, 1, 8'h02, 8'h11, 8'h01, 1, 0, 1); // 24
    add(1, 0, 0, 0, 8'h00, 1, 8'h03, 8'h12, 8'h02, 1, 0, 1); // 25
    add(1, 0, 0, 0, 8'h00, 1, 8'h03, 8'hFF, 8'h03, 1, 0, 0); // 26 halt fetched
    add(1, 1, 0, 1, 8'h80, 1, 8'h03, 8'hFF, 8'h03, 0, 1, 1); // 27 halted, inputs ignored
    add(1, 0, 1, 1, 8'h90, 1, 8'h03, 8'hFF, 8'h03, 0, 1, 1); // 28
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 29 reset leaves halt
    add(1, 1, 0, 1, 8'h22, 0, 8'h22, 8'h00, 8'h00, 0, 0, 1); // 30 start+redirect in idle
    add(0, 0, 1, 1, 8'h55, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 31 reset at pc=22 in run
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 32 idle again
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1); // 33 still no fetch

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_n             = tbl[i].rn;
      bus.start           = tbl[i].st;
      bus.stall           = tbl[i].sl;
      bus.redirect        = tbl[i].rd;
      bus.redirect_target = tbl[i].tgt;
      halt_en             = tbl[i].he;
      e.idx = i; e.ra = tbl[i].ra; e.ir = tbl[i].ir; e.irpc = tbl[i].irpc;
      e.v = tbl[i].v; e.h = tbl[i].h; e.hc = tbl[i].hc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check8(e.idx, "read_address", bus.read_address, e.ra);
      check8(e.idx, "ir", bus.ir, e.ir);
      check8(e.idx, "ir_pc", bus.ir_pc, e.irpc);
      check8(e.idx, "ir_valid", {7'd0, bus.ir_valid}, {7'd0, e.v});
      if (e.hc) check8(e.idx, "halted", {7'd0, bus.halted}, {7'd0, e.h});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
